// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified I/D memory-line arbiter.
// Side encoding doubles as the round-robin history bit.
package mem_arb_pkg;

  localparam int LINE_WIDTH = 64;
  localparam int WORD_SIZE  = 16;
  localparam int CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the
// side that was not granted last. Purely combinational; history lives in the parent.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       req_i,
  input  logic       req_d,
  input  side_t      last_grant,
  output logic [1:0] grant
);

  // grant[0] = I side, grant[1] = D side; at most one bit set.
  always_comb begin
    case ({req_d, req_i})
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == SIDE_I) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache: one access
// at a time, strobes held for LATENCY cycles (1..15), then a one-cycle ack.
module mem_line_arbiter #(
  parameter int WORD_SIZE  = mem_arb_pkg::WORD_SIZE,
  parameter int LINE_WIDTH = mem_arb_pkg::LINE_WIDTH,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic                  d_req,
  input  logic                  i_we,
  input  logic                  d_we,
  input  logic [WORD_SIZE-1:0]  i_addr,
  input  logic [WORD_SIZE-1:0]  d_addr,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  i_ack,
  output logic                  d_ack,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  m_readM,
  output logic                  m_writeM,
  output logic [WORD_SIZE-1:0]  m_address,
  output logic [LINE_WIDTH-1:0] m_wdata,
  input  logic [LINE_WIDTH-1:0] m_rdata,
  output logic [15:0]           i_grants,
  output logic [15:0]           d_grants
);

  import mem_arb_pkg::state_t, mem_arb_pkg::IDLE, mem_arb_pkg::BUSY, mem_arb_pkg::ACK;
  import mem_arb_pkg::side_t, mem_arb_pkg::SIDE_I, mem_arb_pkg::SIDE_D;
  import mem_arb_pkg::CNT_WIDTH;

  state_t                state, next_state;
  side_t                 last_grant, cur_side, grant_side;
  logic                  cur_we;
  logic [WORD_SIZE-1:0]  cur_addr;
  logic [LINE_WIDTH-1:0] cur_wdata;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [1:0]            grant;
  logic                  last_beat;

  rr_arbiter2 u_rr (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign grant_side = grant[1] ? SIDE_D : SIDE_I;
  assign last_beat  = (cnt == CNT_WIDTH'(LATENCY - 1));

  // Memory port comes straight from the latched request, so it cannot move mid-access.
  assign m_address = cur_addr & ~WORD_SIZE'(3);
  assign m_wdata   = cur_wdata;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every always_comb output gets a default first; a missed branch would
  // otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|grant) next_state = BUSY;
      BUSY:    if (last_beat) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    m_readM  = 1'b0;
    m_writeM = 1'b0;
    i_ack    = 1'b0;
    d_ack    = 1'b0;
    case (state)
      BUSY: begin
        m_readM  = ~cur_we;
        m_writeM = cur_we;
      end
      ACK: begin
        i_ack = (cur_side == SIDE_I);
        d_ack = (cur_side == SIDE_D);
      end
      default: ;
    endcase
  end

  // NOTE: the latched request and rdata registers drive outputs directly, so
  // they are reset alongside control; leaving them unreset would expose stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= SIDE_I;
      cur_side   <= SIDE_I;
      cur_we     <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      cnt        <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_grants   <= '0;
      d_grants   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            cur_side   <= grant_side;
            last_grant <= grant_side;
            cur_we     <= grant[1] ? d_we    : i_we;
            cur_addr   <= grant[1] ? d_addr  : i_addr;
            cur_wdata  <= grant[1] ? d_wdata : i_wdata;
            cnt        <= '0;
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_WIDTH'(1);
          if (last_beat && !cur_we) begin
            if (cur_side == SIDE_D) d_rdata <= m_rdata;
            else                    i_rdata <= m_rdata;
          end
        end
        ACK: begin
          if (cur_side == SIDE_D) d_grants <= d_grants + 16'd1;
          else                    i_grants <= i_grants + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized traffic against a transaction-level round-robin/memory model.
module tb_mem_line_arbiter;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, i_we = 1'b0, d_we = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0;
  logic [63:0] i_wdata = '0, d_wdata = '0;
  logic        i_ack, d_ack, m_readM, m_writeM;
  logic [63:0] i_rdata, d_rdata, m_wdata;
  logic [63:0] m_rdata = '0;
  logic [15:0] m_address, i_grants, d_grants;

  mem_line_arbiter #(.WORD_SIZE(16), .LINE_WIDTH(64), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .d_req(d_req), .i_we(i_we), .d_we(d_we),
    .i_addr(i_addr), .d_addr(d_addr), .i_wdata(i_wdata), .d_wdata(d_wdata),
    .i_ack(i_ack), .d_ack(d_ack), .i_rdata(i_rdata), .d_rdata(d_rdata),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address),
    .m_wdata(m_wdata), .m_rdata(m_rdata),
    .i_grants(i_grants), .d_grants(d_grants)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Transaction-level reference state.
  bit          model_last;   // 0 = I granted last, 1 = D
  logic [15:0] exp_i_grants, exp_d_grants;
  logic [63:0] exp_i_rdata, exp_d_rdata;
  logic [63:0] env_mem [logic [15:0]];
  logic [63:0] ref_mem [logic [15:0]];

  function automatic logic [63:0] default_line(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, 16'hC0DE};
  endfunction

  function automatic logic [63:0] env_read(input logic [15:0] a);
    return env_mem.exists(a) ? env_mem[a] : default_line(a);
  endfunction

  function automatic logic [63:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_line(a);
  endfunction

  // Memory behind the port: stores written lines, returns lines for reads.
  always @(negedge clk) begin
    if (m_writeM) env_mem[m_address] = m_wdata;
    m_rdata = m_readM ? env_read(m_address) : 64'h0BAD_0BAD_0BAD_0BAD;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic set_side(input bit side, input bit we, input logic [15:0] addr,
                          input logic [63:0] wdata);
    if (side) begin d_we = we; d_addr = addr; d_wdata = wdata; end
    else      begin i_we = we; i_addr = addr; i_wdata = wdata; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_last = 1'b0;
    exp_i_grants = '0; exp_d_grants = '0;
    exp_i_rdata  = '0; exp_d_rdata  = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"},   {m_readM, m_writeM, i_ack, d_ack}, '0);
    check({tag, "_addr"},  m_address, '0);
    check({tag, "_wdata"}, m_wdata, '0);
    check({tag, "_irdat"}, i_rdata, '0);
    check({tag, "_drdat"}, d_rdata, '0);
    check({tag, "_cnts"},  {i_grants, d_grants}, '0);
  endtask

  // Follows one granted access from the negedge before its BUSY phase through
  // the IDLE cycle after its ack; ends at that IDLE negedge.
  task automatic watch_txn(input bit side, input bit we, input logic [15:0] exp_addr,
                           input logic [63:0] wdata, input logic [63:0] exp_rdata,
                           input bit keep, output int ack_cyc);
    int n;
    int busy;
    n = 0;
    do begin @(negedge clk); n++; end while (!(m_readM || m_writeM) && n < 4);
    busy = 0;
    while ((m_readM || m_writeM) && busy < 20) begin
      check("busy_bus", {m_readM, m_writeM, i_ack, d_ack, 12'h0, m_address},
                        {!we, we, 2'b00, 12'h0, exp_addr});
      if (we) check("busy_wdata", m_wdata, wdata);
      busy++;
      @(negedge clk);
    end
    check("busy_len", busy, LAT);
    check("ack", {i_ack, d_ack}, {!side, side});
    ack_cyc = cycle;
    if (!we) begin
      if (side) exp_d_rdata = exp_rdata;
      else      exp_i_rdata = exp_rdata;
    end
    check("i_rdata", i_rdata, exp_i_rdata);
    check("d_rdata", d_rdata, exp_d_rdata);
    if (side) exp_d_grants++;
    else      exp_i_grants++;
    if (we) ref_mem[exp_addr] = wdata;
    if (!keep) begin
      if (side) d_req = 1'b0;
      else      i_req = 1'b0;
    end
    @(negedge clk);
    check("idle_after", {m_readM, m_writeM, i_ack, d_ack}, '0);
    check("grants", {i_grants, d_grants}, {exp_i_grants, exp_d_grants});
  endtask

  typedef struct {
    bit          side;
    bit          we;
    logic [15:0] addr;
    logic [63:0] wdata;
    bit          preload;
    logic [63:0] mem_line;
    logic [15:0] exp_addr;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1, "timeout");
  end

  initial begin
    int a0, a1, a2, a3;
    bit pi, pd, w, wei, wed;
    logic [15:0] ai, ad;
    logic [63:0] wi, wd;

    //            side we  addr      wdata                  pre  mem_line               exp_addr  exp_rdata
    vecs[0] = '{1'b0, 1'b0, 16'h0013, 64'h0,                1'b1, 64'h0004_0003_0002_0001, 16'h0010, 64'h0004_0003_0002_0001};
    vecs[1] = '{1'b1, 1'b1, 16'h0020, 64'hFFFF_0000_1234_ABCD, 1'b0, 64'h0,                16'h0020, 64'h0};
    vecs[2] = '{1'b1, 1'b0, 16'h0022, 64'h0,                1'b0, 64'h0,                   16'h0020, 64'hFFFF_0000_1234_ABCD};
    vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0,                16'hFFFC, 64'h0};
    vecs[4] = '{1'b0, 1'b0, 16'hFFFE, 64'h0,                1'b0, 64'h0,                   16'hFFFC, 64'h0123_4567_89AB_CDEF};

    do_reset();
    check_zero("reset");

    // Directed single accesses.
    foreach (vecs[k]) begin
      if (vecs[k].preload) begin
        env_mem[vecs[k].exp_addr] = vecs[k].mem_line;
        ref_mem[vecs[k].exp_addr] = vecs[k].mem_line;
      end
      set_side(vecs[k].side, vecs[k].we, vecs[k].addr, vecs[k].wdata);
      if (vecs[k].side) d_req = 1'b1; else i_req = 1'b1;
      watch_txn(vecs[k].side, vecs[k].we, vecs[k].exp_addr, vecs[k].wdata,
                vecs[k].exp_rdata, 1'b0, a0);
      model_last = vecs[k].side;
    end

    // Tie right after reset, both held: D, I, D, I at LAT+2 spacing.
    do_reset();
    set_side(1'b0, 1'b0, 16'h0040, '0);
    set_side(1'b1, 1'b0, 16'h0080, '0);
    i_req = 1'b1; d_req = 1'b1;
    watch_txn(1'b1, 1'b0, 16'h0080, '0, ref_read(16'h0080), 1'b1, a0);
    watch_txn(1'b0, 1'b0, 16'h0040, '0, ref_read(16'h0040), 1'b1, a1);
    watch_txn(1'b1, 1'b0, 16'h0080, '0, ref_read(16'h0080), 1'b1, a2);
    watch_txn(1'b0, 1'b0, 16'h0040, '0, ref_read(16'h0040), 1'b0, a3);
    d_req = 1'b0;
    model_last = 1'b0;
    check("tie_gap1", a1 - a0, LAT + 2);
    check("tie_gap2", a2 - a1, LAT + 2);
    check("tie_gap3", a3 - a2, LAT + 2);

    // D arrives during I's BUSY: waits for the IDLE after I's ack.
    set_side(1'b0, 1'b0, 16'h0101, '0);
    set_side(1'b1, 1'b1, 16'h0202, 64'hA5A5_5A5A_0F0F_F0F0);
    i_req = 1'b1;
    fork
      begin repeat (2) @(negedge clk); d_req = 1'b1; end
    join_none
    watch_txn(1'b0, 1'b0, 16'h0100, '0, ref_read(16'h0100), 1'b0, a0);
    watch_txn(1'b1, 1'b1, 16'h0200, 64'hA5A5_5A5A_0F0F_F0F0, '0, 1'b0, a1);
    model_last = 1'b1;

    // Reset in the 2nd BUSY cycle of a D read aborts it; tie afterwards goes to D.
    set_side(1'b1, 1'b0, 16'h0024, '0);
    d_req = 1'b1;
    @(negedge clk);
    check("abort_busy1", {m_readM, m_writeM}, 2'b10);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("abort");
    reset = 1'b0;
    model_last = 1'b0;
    exp_i_grants = '0; exp_d_grants = '0;
    exp_i_rdata  = '0; exp_d_rdata  = '0;
    set_side(1'b0, 1'b0, 16'h0030, '0);
    i_req = 1'b1;
    watch_txn(1'b1, 1'b0, 16'h0024, '0, ref_read(16'h0024), 1'b0, a0);
    watch_txn(1'b0, 1'b0, 16'h0030, '0, ref_read(16'h0030), 1'b0, a1);
    model_last = 1'b0;

    // I-side counter wraps 0xFFFF -> 0; D counter untouched.
    force dut.i_grants = 16'hFFFF;
    @(negedge clk);
    release dut.i_grants;
    exp_i_grants = 16'hFFFF;
    set_side(1'b0, 1'b0, 16'h0050, '0);
    i_req = 1'b1;
    watch_txn(1'b0, 1'b0, 16'h0050, '0, ref_read(16'h0050), 1'b0, a0);
    model_last = 1'b0;
    check("wrap_i", i_grants, 16'h0000);

    // Randomized mixed traffic against the round-robin / memory model.
    for (int r = 0; r < 40; r++) begin
      pd  = 1'($urandom_range(0, 1));
      pi  = pd ? 1'($urandom_range(0, 1)) : 1'b1;
      wei = 1'($urandom_range(0, 1));
      wed = 1'($urandom_range(0, 1));
      ai  = 16'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      ad  = 16'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      wi  = {$urandom, $urandom};
      wd  = {$urandom, $urandom};
      set_side(1'b0, wei, ai, wi);
      set_side(1'b1, wed, ad, wd);
      i_req = pi; d_req = pd;
      while (pi || pd) begin
        w = (pi && pd) ? !model_last : pd;
        if (w) begin
          watch_txn(1'b1, wed, ad & 16'hFFFC, wd, ref_read(ad & 16'hFFFC), 1'b0, a0);
          pd = 1'b0;
        end else begin
          watch_txn(1'b0, wei, ai & 16'hFFFC, wi, ref_read(ai & 16'hFFFC), 1'b0, a0);
          pi = 1'b0;
        end
        model_last = w;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_line_arbiter.md
# mem_line_arbiter

- Shares one 64-bit-line unified memory port between the instruction cache (I-side) and the data cache (D-side) of the pipelined CPU.
- Accepts one line read or line write at a time and holds the memory strobes for a fixed access latency.
- Returns a single-cycle acknowledge with read data to the granted requester.
- Arbitrates simultaneous requests round-robin so neither cache starves during mixed fetch/load/store traffic.

## Interface
Parameters:
- `WORD_SIZE`, 16: address width in bits.
- `LINE_WIDTH`, 64: line data width (4 words).
- `LATENCY`, 4: memory access cycles per request; legal range 1..15.

Ports:
- `clk`  in  1  the single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`, `d_req`  in  1 each  request valid; held with stable fields until the matching ack.
- `i_we`, `d_we`  in  1 each  1 = line write, 0 = line read.
- `i_addr`, `d_addr`  in  WORD_SIZE each  line-aligned address; low 2 bits ignored.
- `i_wdata`, `d_wdata`  in  LINE_WIDTH each  write line.
- `i_ack`, `d_ack`  out  1 each  one-cycle completion pulse.
- `i_rdata`, `d_rdata`  out  LINE_WIDTH each  read line; valid while the matching ack is high, holds last value otherwise.
- `m_readM`, `m_writeM`  out  1 each  memory strobes.
- `m_address`  out  WORD_SIZE  memory address, low 2 bits forced to 0.
- `m_wdata`  out  LINE_WIDTH  memory write line.
- `m_rdata`  in  LINE_WIDTH  memory read line; valid in the last BUSY cycle.
- `i_grants`, `d_grants`  out  16 each  completed-request counters; wrap at 0xFFFF→0.

## Operation
FSM has three states: IDLE, BUSY, ACK.

IDLE:
- If no request is pending, stay in IDLE.
- If only one side is requesting, grant that side.
- If both are requesting, grant the side opposite `last_grant`. `last_grant` resets to I, so the first tie goes to D.
- On a grant: latch side, we, addr and wdata into registers; set `last_grant`; clear cnt; go to BUSY.

BUSY:
- Drive m_readM = ~we and m_writeM = we from the latched request.
- Drive m_address and m_wdata from the latched registers; they stay stable for the whole of BUSY.
- Increment cnt each cycle.
- At the edge where cnt == LATENCY-1:
  - capture m_rdata into the granted side's rdata register (reads only);
  - go to ACK.
  - Writes commit in memory at this same edge.

ACK:
- Strobes low.
- Granted side's ack = 1 for exactly one cycle.
- Increment that side's grant counter.
- Go to IDLE.

General rules:
- The ungranted side's ack stays 0.
- Its rdata register is untouched.
- A requester still asserting req in the IDLE cycle after its ack is treated as a new request.
- Requests seen while in BUSY or ACK are not sampled; they wait for IDLE.

## Timing
- Reset (synchronous, active-high), at the next rising edge:
  - all outputs go to 0: strobes, acks, m_address, m_wdata, rdata registers, counters;
  - state goes to IDLE, `last_grant` goes to I, cnt goes to 0.
- Reset mid-BUSY:
  - aborts the access; no ack is issued;
  - strobes are low in the cycle after the edge;
  - a write in progress is not guaranteed to commit.
- Latency: req sampled in IDLE at edge E → strobes high in cycles E+1 .. E+LATENCY → ack high in cycle E+LATENCY+1.
- Throughput: one request per LATENCY+2 cycles, because of the mandatory IDLE cycle after ACK.
- With LATENCY = 1, BUSY lasts exactly one cycle.
- m_readM and m_writeM are never both high.
- Strobes are 0 in IDLE and ACK.
- Counters are 16-bit unsigned and wrap silently.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, BUSY, ACK);
  - `LINE_WIDTH` = 64 and `WORD_SIZE` = 16 constants;
  - side encoding (SIDE_I = 0, SIDE_D = 1).
- Natural sub-module: `rr_arbiter2`. It is purely combinational: 2 requests + `last_grant` in, one-hot grant out. The `last_grant` register lives in the parent.
- Everything else (FSM, cnt, latch registers, counters) is in `mem_line_arbiter`.

## Test plan
All scenarios use LATENCY = 4.
1. Single I read: i_req=1, i_addr=0x0013, m_rdata=0x0004_0003_0002_0001 → m_address=0x0010; m_readM high 4 cycles; i_ack one cycle later with i_rdata=0x0004_0003_0002_0001; i_grants=1.
2. Single D write: d_we=1, d_addr=0x0020, d_wdata=0xFFFF_0000_1234_ABCD → m_writeM high 4 cycles with those values; d_ack pulses; m_readM stays 0.
3. Tie after reset: i_req and d_req asserted together, both held → grant order D, I, D, I; acks spaced 6 cycles apart; d_grants = i_grants = 2 after 4 acks.
4. Late arrival: i_req high, d_req rises during I's BUSY → D is not granted until the IDLE after i_ack; I's m_address never changes mid-BUSY.
5. Reset mid-op: reset asserted in the 2nd BUSY cycle of a D read → no d_ack; all outputs 0 next cycle; with i_req high on release, the next grant goes to D if d_req is also high, else I.
6. Counter wrap: preload via 65 535 I reads (or force) → the next ack sets i_grants to 0x0000; d_grants is unchanged.
